stream_bridge_fifo: RTL and testbench

STREAM_BRIDGE_FIFO -- requirements
Module: stream_bridge_fifo

---
 rtl/stream_bridge_fifo.sv | 145 ++++++++++++++
 tb/tb_stream_bridge_fifo.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_bridge_fifo.sv
// Single-clock stream bridge. A synchronous-read RAM feeds a prefetch register and a
// registered output stage, so the consumer can stall on any cycle without losing a word.
module stream_bridge_fifo #(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned DEPTH       = 1024,
  parameter int          AFULL_LEVEL = int'(DEPTH) - 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         in_valid,
  input  logic signed [DATA_WIDTH-1:0] in_data,
  output logic                         in_ready,
  output logic                         out_valid,
  output logic signed [DATA_WIDTH-1:0] out_data,
  input  logic                         out_ready,
  output logic [$clog2(DEPTH):0]       level,
  output logic                         almost_full,
  output logic                         overflow,
  output logic [15:0]                  drop_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam logic [LW-1:0] DepthL = LW'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Pointers carry one extra wrap bit so a full RAM is distinguishable from an empty one.
  logic [AW:0]           wr_ptr_q, wr_ptr_d;
  logic [AW:0]           rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]         level_q, level_d;
  logic                  pf_valid_q, pf_valid_d;
  logic [DATA_WIDTH-1:0] pf_data_q;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  overflow_q, overflow_d;
  logic [15:0]           drop_count_q, drop_count_d;

  logic push, drop, pop, out_load, ram_empty, ram_rd, mem_we;

  // Handshake status depends only on registered level.
  assign in_ready    = (level_q < DepthL);
  assign almost_full = (int'(level_q) >= AFULL_LEVEL);

  assign push      = in_valid && in_ready;
  assign drop      = in_valid && !in_ready;
  assign pop       = out_valid_q && out_ready;
  assign out_load  = pf_valid_q && (!out_valid_q || out_ready);
  assign ram_empty = (wr_ptr_q == rd_ptr_q);
  assign ram_rd    = !ram_empty && (!pf_valid_q || out_load);
  assign mem_we    = push && !rst && !flush;

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    level_d      = level_q;
    pf_valid_d   = pf_valid_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    overflow_d   = overflow_q;
    drop_count_d = drop_count_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + (AW + 1)'(1);
    end
    if (ram_rd) begin
      rd_ptr_d = rd_ptr_q + (AW + 1)'(1);
    end

    if (ram_rd) begin
      pf_valid_d = 1'b1;
    end else if (out_load) begin
      pf_valid_d = 1'b0;
    end

    if (out_load) begin
      out_valid_d = 1'b1;
      out_data_d  = pf_data_q;
    end else if (pop) begin
      out_valid_d = 1'b0;
    end

    unique case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase

    if (drop) begin
      overflow_d = 1'b1;
      if (drop_count_q != 16'hFFFF) begin
        drop_count_d = drop_count_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      pf_valid_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      overflow_q   <= 1'b0;
      drop_count_q <= '0;
    end else if (flush) begin
      // out_data deliberately keeps its last value.
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      pf_valid_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      overflow_q   <= 1'b0;
      drop_count_q <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      pf_valid_q   <= pf_valid_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      overflow_q   <= overflow_d;
      drop_count_q <= drop_count_d;
    end
  end

  // RAM with registered read port; the read register is the prefetch stage.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[wr_ptr_q[AW-1:0]] <= in_data;
    end
    if (ram_rd) begin
      pf_data_q <= mem[rd_ptr_q[AW-1:0]];
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign level      = level_q;
  assign overflow   = overflow_q;
  assign drop_count = drop_count_q;

endmodule

// File: tb/tb_stream_bridge_fifo.sv
// Scoreboard bench for stream_bridge_fifo: a negedge monitor keeps an ordered queue of
// accepted words plus occupancy/drop bookkeeping and checks every output against it.
module tb_stream_bridge_fifo;

  localparam int DW    = 16;
  localparam int DEPTH = 16;
  localparam int AFULL = 12;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready = 1'b0;
  logic [4:0]    level;
  logic          almost_full;
  logic          overflow;
  logic [15:0]   drop_count;

  always #5 clk = ~clk;

  stream_bridge_fifo #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .AFULL_LEVEL(AFULL)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .level      (level),
    .almost_full(almost_full),
    .overflow   (overflow),
    .drop_count (drop_count)
  );

  int n_checks = 0;
  int n_pass   = 0;

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
  endfunction

  // Reference model: words in flight in acceptance order, plus occupancy and drop state.
  logic [DW-1:0] exp_q[$];
  int            m_level = 0;
  bit            m_ovf = 1'b0;
  int            m_drops = 0;
  bit            stall_pend = 1'b0;
  logic [DW-1:0] stall_data = '0;

  always @(negedge clk) begin
    bit acc;
    check("level", 32'(level), 32'(m_level));
    check("in_ready", 32'(in_ready), 32'(m_level < DEPTH));
    check("almost_full", 32'(almost_full), 32'(m_level >= AFULL));
    check("overflow", 32'(overflow), 32'(m_ovf));
    check("drop_count", 32'(drop_count), 32'(m_drops));
    if (stall_pend) begin
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_data", 32'(out_data), 32'(stall_data));
    end
    stall_pend = 1'b0;
    if (rst || flush) begin
      exp_q.delete();
      m_level = 0;
      m_ovf   = 1'b0;
      m_drops = 0;
    end else begin
      acc = (m_level < DEPTH);
      if (out_valid && out_ready) begin
        check("pop_has_word", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          check("out_data", 32'(out_data), 32'(exp_q.pop_front()));
          m_level--;
        end
      end
      if (out_valid && !out_ready) begin
        stall_pend = 1'b1;
        stall_data = out_data;
      end
      if (in_valid) begin
        if (acc) begin
          exp_q.push_back(in_data);
          m_level++;
        end else begin
          m_ovf = 1'b1;
          if (m_drops < 65535) m_drops++;
        end
      end
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_n(input int n, input int base);
    out_ready = 1'b0;
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = DW'(base + i);
      cyc();
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    in_valid  = 1'b0;
    for (int i = 0; i < 400 && (level != 0 || out_valid); i++) cyc();
    check("drained", 32'(level), 32'd0);
    out_ready = 1'b0;
  endtask

  // Single word into an empty bridge must be presented after exactly two edges.
  task automatic latency_word(input logic [DW-1:0] w);
    in_valid  = 1'b1;
    in_data   = w;
    out_ready = 1'b1;
    cyc();
    in_valid = 1'b0;
    @(negedge clk);
    check("lat_edge0_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("lat_edge1_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("lat_edge2_valid", 32'(out_valid), 32'd1);
    check("lat_edge2_data", 32'(out_data), 32'(w));
    @(posedge clk);
    #1;
    @(negedge clk);
    check("lat_level_after", 32'(level), 32'd0);
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  initial begin
    int acc_words;
    int seen;

    cyc(3);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    rst = 1'b0;
    cyc();

    latency_word(16'h1234);

    // Fill past capacity with the consumer stalled.
    push_n(20, 0);
    check("full_level", 32'(level), 32'd16);
    check("full_in_ready", 32'(in_ready), 32'd0);
    check("full_almost_full", 32'(almost_full), 32'd1);
    check("full_overflow", 32'(overflow), 32'd1);
    check("full_drops", 32'(drop_count), 32'd4);
    drain();

    // Full bridge with simultaneous offer and pop: pop wins, offer is dropped.
    push_n(16, 100);
    in_valid  = 1'b1;
    in_data   = 16'd999;
    out_ready = 1'b1;
    cyc();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("fullpop_level", 32'(level), 32'd15);
    check("fullpop_drops", 32'(drop_count), 32'd5);
    check("fullpop_in_ready", 32'(in_ready), 32'd1);
    drain();

    // Flush with five words held and a word presented.
    push_n(5, 200);
    cyc(3);
    check("preflush_valid", 32'(out_valid), 32'd1);
    check("preflush_level", 32'(level), 32'd5);
    flush     = 1'b1;
    in_valid  = 1'b1;
    in_data   = 16'd777;
    out_ready = 1'b1;
    cyc();
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("flush_level", 32'(level), 32'd0);
    check("flush_valid", 32'(out_valid), 32'd0);
    check("flush_overflow", 32'(overflow), 32'd0);
    check("flush_drops", 32'(drop_count), 32'd0);
    check("flush_in_ready", 32'(in_ready), 32'd1);
    check("flush_out_data_kept", 32'(out_data), 32'd200);
    latency_word(16'h0BEE);

    // Random traffic with a random consumer.
    acc_words = 0;
    for (int g = 0; g < 60000 && acc_words < 10000; g++) begin
      in_valid  = ($urandom_range(0, 99) < 80);
      in_data   = DW'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      if (in_valid && in_ready) acc_words++;
      cyc();
    end
    in_valid = 1'b0;
    check("random_words", 32'(acc_words), 32'd10000);
    drain();

    // Reset mid-stream with seven words held.
    push_n(7, 300);
    check("prerst_level", 32'(level), 32'd7);
    rst       = 1'b1;
    in_valid  = 1'b1;
    in_data   = 16'd555;
    out_ready = 1'b1;
    cyc();
    rst      = 1'b0;
    in_valid = 1'b0;
    check("rst_level", 32'(level), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data", 32'(out_data), 32'd0);
    check("rst_ready", 32'(in_ready), 32'd1);
    check("rst_afull", 32'(almost_full), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_drops", 32'(drop_count), 32'd0);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (out_valid) seen++;
    end
    check("no_stale_words", 32'(seen), 32'd0);

    cyc();
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
